// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command responder: frame geometry, FSM state
// encoding and the optional SCK-stall watchdog width.
package spi_cmd_pkg;

  localparam int unsigned BYTE_BITS   = 8;
  localparam int unsigned FRAME_BYTES = 3;
  localparam int unsigned CNT_W       = $clog2(BYTE_BITS);
  localparam int unsigned TMO_W       = 12;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StData,
    StResp,
    StDone
  } state_e;

  // States in which SCK edges move bits in or out.
  function automatic logic is_shifting(state_e s);
    return (s == StCmd) || (s == StData) || (s == StResp);
  endfunction

endpackage

// File: rtl/spi_cmd_slave_if.sv
// Pin and register-bus bundle of the SPI command responder. The slave modport
// is the responder; the master modport is the host / control-logic side.
interface spi_cmd_slave_if;
  import spi_cmd_pkg::*;

  logic                 spi_clk;
  logic                 spi_cs;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic [BYTE_BITS-1:0] cmd_addr;
  logic [BYTE_BITS-1:0] cmd_data;
  logic                 cmd_wr;
  logic [BYTE_BITS-1:0] rd_addr;
  logic [BYTE_BITS-1:0] rd_data;
  logic [BYTE_BITS-1:0] status;
  logic                 frame_err;
  logic                 busy;

  modport slave (
    input  spi_clk, spi_cs, spi_mosi, rd_data, status,
    output spi_miso, cmd_addr, cmd_data, cmd_wr, rd_addr, frame_err, busy
  );

  modport master (
    output spi_clk, spi_cs, spi_mosi, rd_data, status,
    input  spi_miso, cmd_addr, cmd_data, cmd_wr, rd_addr, frame_err, busy
  );

endinterface

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for an asynchronous input, with single-cycle rise
// and fall pulses derived from consecutive synchronised samples.
module spi_in_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the chain and keep the last synced sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_cmd_slave.sv
// SPI (CPOL=0, MSB first) command responder oversampled on clk_12mhz.
// Frame: command byte, data byte, response byte while CS is low. Emits a
// one-cycle register-write strobe and returns status / echo / readback on MISO.
// Optional SCK-stall watchdog enabled by defining SPI_TIMEOUT_EN.
module spi_cmd_slave
  import spi_cmd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input logic            clk_12mhz,
  input logic            reset,
  spi_cmd_slave_if.slave bus
);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk_12mhz),
    .reset (reset),
    .din   (bus.spi_clk),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk_12mhz),
    .reset (reset),
    .din   (bus.spi_cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Plain synchroniser for MOSI; it is only sampled on synced SCK falls.
  always_ff @(posedge clk_12mhz) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // CS level already covers frame end; SCK level is not needed.
  logic unused_sync;
  assign unused_sync = ^{sck_level, cs_rise};

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [BYTE_BITS-1:0] rx_q, tx_q;
  logic [BYTE_BITS-1:0] cmd_addr_q, cmd_data_q, rd_addr_q;
  logic                 wr_pend_q, cmd_wr_q, frame_err_q, busy_q, miso_q;
  logic                 tmo_hit;

  logic                 byte_last, start, shift_rx, count, shift_tx;
  logic                 load_echo, set_pend, do_write, abort_err, tmo_err;
  logic [BYTE_BITS-1:0] rx_next;

`ifdef SPI_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q;

  // Watchdog counts cycles since the last synced SCK edge while shifting.
  always_ff @(posedge clk_12mhz) begin
    if (reset)                                                tmo_cnt_q <= '0;
    else if (!is_shifting(state_q) || sck_rise || sck_fall)   tmo_cnt_q <= '0;
    else if (!tmo_hit)                                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end
  assign tmo_hit = is_shifting(state_q) && (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
  // Timeout length has no effect without the watchdog.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register.
  always_ff @(posedge clk_12mhz) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic; CS high always wins over SCK activity and timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cs_fall) state_d = StCmd;
      StCmd: begin
        if (cs_level)       state_d = StIdle;
        else if (tmo_hit)   state_d = StDone;
        else if (load_echo) state_d = StData;
      end
      StData: begin
        if (cs_level)      state_d = StIdle;
        else if (tmo_hit)  state_d = StDone;
        else if (do_write) state_d = StResp;
      end
      StResp: begin
        if (cs_level)                state_d = StIdle;
        else if (tmo_hit)            state_d = StDone;
        else if (count && byte_last) state_d = StDone;
      end
      StDone: if (cs_level) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath control strobes decoded from state and synced pin events.
  always_comb begin
    byte_last = (bit_cnt_q == CNT_W'(BYTE_BITS - 1));
    rx_next   = {rx_q[BYTE_BITS-2:0], mosi_s};
    start     = (state_q == StIdle) && cs_fall;
    shift_rx  = sck_fall && !cs_level && !tmo_hit && !wr_pend_q &&
                ((state_q == StCmd) || (state_q == StData));
    count     = shift_rx || (sck_fall && !cs_level && !tmo_hit && (state_q == StResp));
    shift_tx  = sck_rise && !cs_level && !tmo_hit && is_shifting(state_q);
    load_echo = shift_rx && (state_q == StCmd) && byte_last;
    set_pend  = shift_rx && (state_q == StData) && byte_last;
    do_write  = wr_pend_q && (state_q == StData) && !cs_level && !tmo_hit;
    abort_err = cs_level && (((state_q == StCmd) && (bit_cnt_q != '0)) || (state_q == StData));
    tmo_err   = tmo_hit && !cs_level;
  end

  // Shift registers, command registers and output pulses.
  always_ff @(posedge clk_12mhz) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      rd_addr_q   <= '0;
      wr_pend_q   <= 1'b0;
      cmd_wr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      busy_q      <= (state_d != StIdle);
      cmd_wr_q    <= do_write;
      frame_err_q <= abort_err || tmo_err;
      wr_pend_q   <= set_pend;

      if (start || (state_d == StIdle)) bit_cnt_q <= '0;
      else if (count)                   bit_cnt_q <= bit_cnt_q + 1'b1;

      if (shift_rx)  rx_q      <= rx_next;
      if (load_echo) rd_addr_q <= rx_next;
      if (do_write) begin
        cmd_addr_q <= rd_addr_q;
        cmd_data_q <= rx_q;
      end

      if (start)          tx_q <= bus.status;
      else if (load_echo) tx_q <= rx_next;
      else if (do_write)  tx_q <= bus.rd_data;
      else if (shift_tx)  tx_q <= {tx_q[BYTE_BITS-2:0], 1'b0};

      if ((state_d == StIdle) || (state_d == StDone)) miso_q <= 1'b0;
      else if (shift_tx)                              miso_q <= tx_q[BYTE_BITS-1];
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_data  = cmd_data_q;
  assign bus.cmd_wr    = cmd_wr_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Randomised self-checking bench for spi_cmd_slave. A frame-level model
// predicts MISO bytes, register writes and error pulses from the bytes sent.
`timescale 1ns/1ps
module tb_spi_cmd_slave;

  localparam int unsigned SYNC = 2;
  localparam int HALF = 6;   // clk cycles per SCK half period
  localparam int GAP  = 48;  // about 4 us of CS high at 12 MHz

  logic clk = 1'b0;
  logic reset;
  always #42 clk = ~clk;

  spi_cmd_slave_if bus ();

  spi_cmd_slave #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_12mhz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  logic [7:0] rd_mem [256];
  always_comb bus.rd_data = rd_mem[bus.rd_addr];

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int exp_err  = 0;
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every write strobe and error pulse seen on the bus.
  always @(negedge clk) begin
    if (bus.cmd_wr === 1'b1) got_q.push_back({bus.cmd_addr, bus.cmd_data});
    if (bus.frame_err === 1'b1) err_seen++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock out n bits MSB first from word[31:...]; MISO sampled before each fall.
  task automatic spi_bits(input logic [31:0] word, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      bus.spi_clk  = 1'b1;
      bus.spi_mosi = word[31-i];
      wait_clk(HALF);
      rx[31-i]    = bus.spi_miso;
      bus.spi_clk = 1'b0;
      wait_clk(HALF);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat, input logic [7:0] st,
                           input int nbits, output logic [31:0] rx);
    bus.status = st;
    wait_clk(2);
    bus.spi_cs = 1'b0;
    wait_clk(HALF);
    check_eq("busy_on", {31'd0, bus.busy}, 32'd1);
    spi_bits({cmd, dat, 16'h0000}, nbits, rx);
    bus.spi_cs = 1'b1;
    wait_clk(GAP);
  endtask

  // Frame-level model: MISO = status, echoed command, readback, then zeros.
  task automatic expect_frame(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                              input logic [7:0] st, input int nbits, input logic [31:0] rx);
    logic [31:0] exp_rx;
    logic [31:0] mask;
    exp_rx = {st, cmd, rd_mem[cmd], 8'h00};
    mask   = ~(32'hFFFF_FFFF >> nbits);
    check_eq({tag, "_miso"}, rx & mask, exp_rx & mask);
    if (nbits >= 16)     exp_q.push_back({cmd, dat});
    else if (nbits > 0)  exp_err++;
  endtask

  task automatic check_writes(input string tag);
    check_eq({tag, "_wr_cnt"}, got_q.size(), exp_q.size());
    check_eq({tag, "_err_cnt"}, err_seen, exp_err);
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_wr"}, {16'd0, got_q.pop_front()}, {16'd0, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
    check_eq({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_miso_idle"}, {31'd0, bus.spi_miso}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cmd_addr"}, {24'd0, bus.cmd_addr}, 32'd0);
    check_eq({tag, "_cmd_data"}, {24'd0, bus.cmd_data}, 32'd0);
    check_eq({tag, "_rd_addr"}, {24'd0, bus.rd_addr}, 32'd0);
    check_eq({tag, "_cmd_wr"}, {31'd0, bus.cmd_wr}, 32'd0);
    check_eq({tag, "_frame_err"}, {31'd0, bus.frame_err}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_miso"}, {31'd0, bus.spi_miso}, 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rx;
    logic [7:0]  c, d, s;
    int          n;

    for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom);
    rd_mem[1]    = 8'h3C;
    bus.spi_clk  = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.status   = 8'h00;
    reset        = 1'b1;
    wait_clk(4);
    check_reset_vals("rst");
    reset = 1'b0;
    wait_clk(GAP);

    // Basic frame with known status and readback.
    run_frame(8'h01, 8'h11, 8'hA5, 24, rx);
    expect_frame("basic", 8'h01, 8'h11, 8'hA5, 24, rx);
    check_eq("basic_miso_bytes", rx[31:8], 32'hA5013C);
    check_writes("basic");

    // Abort after 12 bits, then the same command in full.
    run_frame(8'h03, 8'h02, 8'h77, 12, rx);
    expect_frame("abort", 8'h03, 8'h02, 8'h77, 12, rx);
    check_writes("abort");
    run_frame(8'h03, 8'h02, 8'h77, 24, rx);
    expect_frame("abort_retry", 8'h03, 8'h02, 8'h77, 24, rx);
    check_writes("abort_retry");

    // Five back-to-back frames.
    for (int k = 1; k <= 5; k++) begin
      run_frame(8'h02, 8'(k), 8'(k * 17), 24, rx);
      expect_frame("b2b", 8'h02, 8'(k), 8'(k * 17), 24, rx);
    end
    check_writes("b2b");

    // Reset in the data byte with CS held low; the rest of the frame is ignored.
    bus.status = 8'h5A;
    wait_clk(2);
    bus.spi_cs = 1'b0;
    wait_clk(HALF);
    spi_bits(32'h0177_0000, 12, rx);
    reset = 1'b1;
    wait_clk(2);
    check_reset_vals("rst_mid");
    reset = 1'b0;
    spi_bits(32'h7000_0000, 12, rx);
    check_eq("rst_mid_idle_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_mid_idle_miso", rx, 32'd0);
    bus.spi_cs = 1'b1;
    wait_clk(GAP);
    check_writes("rst_mid");
    run_frame(8'h01, 8'h4F, 8'hC3, 24, rx);
    expect_frame("post_rst", 8'h01, 8'h4F, 8'hC3, 24, rx);
    check_writes("post_rst");

    // SCK stall after 5 bits.
    bus.status = 8'h96;
    wait_clk(2);
    bus.spi_cs = 1'b0;
    wait_clk(HALF);
    spi_bits(32'hA000_0000, 5, rx);
    wait_clk(150);
`ifdef SPI_TIMEOUT_EN
    exp_err++;
`endif
    check_eq("stall_err", err_seen, exp_err);
    check_eq("stall_busy", {31'd0, bus.busy}, 32'd1);
    spi_bits(32'hE000_0000, 3, rx);
`ifdef SPI_TIMEOUT_EN
    check_eq("stall_late_miso", rx[31:29], 32'd0);
`else
    check_eq("stall_late_miso", rx[31:29], 32'h6);
`endif
    bus.spi_cs = 1'b1;
    wait_clk(GAP);
`ifndef SPI_TIMEOUT_EN
    exp_err++;
`endif
    check_writes("stall");

    // 32 SCK periods in one CS window.
    c = 8'($urandom);
    d = 8'($urandom);
    s = 8'($urandom);
    run_frame(c, d, s, 32, rx);
    expect_frame("long", c, d, s, 32, rx);
    check_eq("long_tail_zero", rx[7:0], 32'd0);
    check_writes("long");

    // Random frames, some cut short.
    for (int k = 0; k < 16; k++) begin
      c = 8'($urandom);
      d = 8'($urandom);
      s = 8'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 24;
      run_frame(c, d, s, n, rx);
      expect_frame("rand", c, d, s, n, rx);
      check_writes("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
